// File: rtl/multicycle_cu_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
// This includes the FSM states, ALU opcodes, instruction cmd/op fields and condition codes.
package multicycle_cu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // The reserved code 1111 falls to the default and never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    ok = 1'b0;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_cu_fsm.sv
// Main multicycle FSM: state register, next-state logic and Moore datapath decode.
// Writes leave here ungated; the top qualifies them with the condition result.
module multicycle_cu_fsm
  import multicycle_cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic       funct_imm,
  input  logic       funct_load,
  input  logic       no_write,
  output logic       decode_en,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       alu_op,
  output logic       adr_src,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src
);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    decode_en  = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        next_pc    = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        decode_en  = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct_imm ? EXECI : EXECR;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: reg_w = ~no_write;
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit top: ALU decode, NZCV flag register, condition latch
// and the condition gating of PC, register-file and memory writes.
module multicycle_control_unit
  import multicycle_cu_pkg::*;
#(
  parameter int ALU_CTRL_W = 2,
  parameter bit EN_EOR     = (ALU_CTRL_W > 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            flags,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic decode_en, next_pc, reg_w, mem_w, branch, alu_op, no_write, pcs;
  logic [3:0] cmd;
  logic [1:0] flag_w;
  logic [ALU_CTRL_W-1:0] alu_sel;
  logic [3:0] flags_q, flags_d;
  logic cond_ex_q, cond_ex_d;

  assign cmd = funct[4:1];

  multicycle_cu_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct_imm  (funct[5]),
    .funct_load (funct[0]),
    .no_write   (no_write),
    .decode_en  (decode_en),
    .next_pc    (next_pc),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .branch     (branch),
    .alu_op     (alu_op),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src)
  );

  // Unrecognised cmds (and EOR when not built in) compute ADD but never write back.
  always_comb begin
    alu_sel  = ALU_CTRL_W'(ALU_ADD);
    no_write = 1'b0;
    case (cmd)
      CMD_ADD: alu_sel = ALU_CTRL_W'(ALU_ADD);
      CMD_SUB: alu_sel = ALU_CTRL_W'(ALU_SUB);
      CMD_AND: alu_sel = ALU_CTRL_W'(ALU_AND);
      CMD_ORR: alu_sel = ALU_CTRL_W'(ALU_ORR);
      CMD_CMP: begin
        alu_sel  = ALU_CTRL_W'(ALU_SUB);
        no_write = 1'b1;
      end
      CMD_EOR: begin
        if (EN_EOR) alu_sel = ALU_CTRL_W'(ALU_EOR);
        else        no_write = 1'b1;
      end
      default: no_write = 1'b1;
    endcase
    flag_w[1] = funct[0];
    flag_w[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
  end

  assign alu_control = alu_op ? alu_sel : ALU_CTRL_W'(ALU_ADD);

  // The condition is sampled once in DECODE so that flags written in EXEC only affect later instructions.
  always_comb begin
    cond_ex_d = decode_en ? cond_holds(cond, flags_q) : cond_ex_q;
    flags_d   = flags_q;
    if (alu_op && cond_ex_q) begin
      if (flag_w[1]) flags_d[3:2] = flags[3:2];
      if (flag_w[0]) flags_d[1:0] = flags[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign pcs       = ((rd == 4'd15) & reg_w) | branch;
  assign pc_write  = next_pc | (pcs & cond_ex_q);
  assign reg_write = reg_w & cond_ex_q;
  assign mem_write = mem_w & cond_ex_q;
  assign imm_src   = op;
  assign reg_src   = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model predicts every cycle's outputs
// for an EOR-enabled (3-bit) and a base (2-bit) control unit driven in parallel.
module tb_multicycle_control_unit;

  typedef enum int {
    PH_FETCH, PH_DECODE, PH_ADDR, PH_LOAD, PH_LOADWB, PH_STORE,
    PH_EXEC, PH_EXECWB, PH_BRANCH, PH_UNDEF
  } phase_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu;
  } outs_t;

  logic       clk, rst;
  logic [3:0] cond, rd, flags;
  logic [1:0] op;
  logic [5:0] funct;

  logic       pc_write_3, adr_src_3, mem_write_3, ir_write_3, reg_write_3, alu_src_a_3;
  logic [1:0] result_src_3, alu_src_b_3, imm_src_3, reg_src_3;
  logic [2:0] alu_control_3;
  logic       pc_write_2, adr_src_2, mem_write_2, ir_write_2, reg_write_2, alu_src_a_2;
  logic [1:0] result_src_2, alu_src_b_2, imm_src_2, reg_src_2;
  logic [1:0] alu_control_2;

  int    checks = 0;
  int    errors = 0;
  bit    cmp_en = 0;
  int    phase_idx = 0;
  outs_t exp3, exp2;
  logic [7:0] rw_mask3, rw_mask2, mw_mask, pw_mask, adr_mask;
  logic [2:0] alu_at3 [8];
  logic [2:0] alu_at2 [8];
  logic [3:0] m_flags;
  bit         m_cond_ex;

  multicycle_control_unit #(.ALU_CTRL_W(3)) dut3 (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd), .flags(flags),
    .pc_write(pc_write_3), .adr_src(adr_src_3), .mem_write(mem_write_3),
    .ir_write(ir_write_3), .reg_write(reg_write_3), .result_src(result_src_3),
    .alu_src_a(alu_src_a_3), .alu_src_b(alu_src_b_3), .imm_src(imm_src_3),
    .reg_src(reg_src_3), .alu_control(alu_control_3)
  );

  multicycle_control_unit #(.ALU_CTRL_W(2)) dut2 (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd), .flags(flags),
    .pc_write(pc_write_2), .adr_src(adr_src_2), .mem_write(mem_write_2),
    .ir_write(ir_write_2), .reg_write(reg_write_2), .result_src(result_src_2),
    .alu_src_a(alu_src_a_2), .alu_src_b(alu_src_b_2), .imm_src(imm_src_2),
    .reg_src(reg_src_2), .alu_control(alu_control_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Condition test written as base predicate on cond[3:1], inverted by cond[0].
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] c, input bit eor_en);
    if (c == 4'b0010 || c == 4'b1010) return 3'd1;
    if (c == 4'b0000) return 3'd2;
    if (c == 4'b1100) return 3'd3;
    if (c == 4'b0001 && eor_en) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit alu_writes(input logic [3:0] c, input bit eor_en);
    return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100) ||
           (c == 4'b0001 && eor_en);
  endfunction

  function automatic outs_t expect_outs(input phase_t ph, input logic [1:0] o, input logic [5:0] f,
                                        input logic [3:0] r, input bit ce, input bit eor_en);
    outs_t e;
    bit wr;
    e = '0;
    wr = alu_writes(f[4:1], eor_en);
    e.imm_src = o;
    e.reg_src = {o == 2'b01, o == 2'b10};
    case (ph)
      PH_FETCH:  begin e.ir_write = 1; e.pc_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      PH_DECODE: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      PH_ADDR:   e.alu_src_b = 2'b01;
      PH_LOAD:   e.adr_src = 1;
      PH_LOADWB: begin e.result_src = 2'b01; e.reg_write = ce; e.pc_write = ce && (r == 4'd15); end
      PH_STORE:  begin e.adr_src = 1; e.mem_write = ce; end
      PH_EXEC:   begin e.alu_src_b = f[5] ? 2'b01 : 2'b00; e.alu = alu_code(f[4:1], eor_en); end
      PH_EXECWB: begin e.reg_write = ce && wr; e.pc_write = ce && wr && (r == 4'd15); end
      PH_BRANCH: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pc_write = ce; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cmp_outs(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".pc_write"},   8'(a.pc_write),   8'(e.pc_write));
    chk({tag, ".adr_src"},    8'(a.adr_src),    8'(e.adr_src));
    chk({tag, ".mem_write"},  8'(a.mem_write),  8'(e.mem_write));
    chk({tag, ".ir_write"},   8'(a.ir_write),   8'(e.ir_write));
    chk({tag, ".reg_write"},  8'(a.reg_write),  8'(e.reg_write));
    chk({tag, ".result_src"}, 8'(a.result_src), 8'(e.result_src));
    chk({tag, ".alu_src_a"},  8'(a.alu_src_a),  8'(e.alu_src_a));
    chk({tag, ".alu_src_b"},  8'(a.alu_src_b),  8'(e.alu_src_b));
    chk({tag, ".imm_src"},    8'(a.imm_src),    8'(e.imm_src));
    chk({tag, ".reg_src"},    8'(a.reg_src),    8'(e.reg_src));
    chk({tag, ".alu"},        8'(a.alu),        8'(e.alu));
  endtask

  task automatic checkOutput();
    outs_t a3, a2;
    a3 = {pc_write_3, adr_src_3, mem_write_3, ir_write_3, reg_write_3, result_src_3,
          alu_src_a_3, alu_src_b_3, imm_src_3, reg_src_3, alu_control_3};
    a2 = {pc_write_2, adr_src_2, mem_write_2, ir_write_2, reg_write_2, result_src_2,
          alu_src_a_2, alu_src_b_2, imm_src_2, reg_src_2, 1'b0, alu_control_2};
    cmp_outs($sformatf("w3.ph%0d", phase_idx), a3, exp3);
    cmp_outs($sformatf("w2.ph%0d", phase_idx), a2, exp2);
    rw_mask3[phase_idx] = reg_write_3;
    rw_mask2[phase_idx] = reg_write_2;
    mw_mask[phase_idx]  = mem_write_3;
    pw_mask[phase_idx]  = pc_write_3;
    adr_mask[phase_idx] = adr_src_3;
    alu_at3[phase_idx]  = alu_control_3;
    alu_at2[phase_idx]  = {1'b0, alu_control_2};
  endtask

  always @(negedge clk) if (cmp_en) checkOutput();

  task automatic doReset();
    cmp_en = 0;
    rst = 1'b1;
    #1;
    chk("rst.ir_write",  8'(ir_write_3),  8'd1);
    chk("rst.pc_write",  8'(pc_write_3),  8'd1);
    chk("rst.reg_write", 8'(reg_write_3), 8'd0);
    chk("rst.mem_write", 8'(mem_write_3), 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_flags = 4'b0000;
    m_cond_ex = 0;
  endtask

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [3:0] r, input logic [3:0] fl, input int abort_at = -1);
    phase_t plan[$];
    plan.push_back(PH_FETCH);
    plan.push_back(PH_DECODE);
    case (o)
      2'b01: begin
        plan.push_back(PH_ADDR);
        if (f[0]) begin plan.push_back(PH_LOAD); plan.push_back(PH_LOADWB); end
        else plan.push_back(PH_STORE);
      end
      2'b00: begin plan.push_back(PH_EXEC); plan.push_back(PH_EXECWB); end
      2'b10: plan.push_back(PH_BRANCH);
      default: plan.push_back(PH_UNDEF);
    endcase
    cond = c; op = o; funct = f; rd = r; flags = fl;
    rw_mask3 = '0; rw_mask2 = '0; mw_mask = '0; pw_mask = '0; adr_mask = '0;
    foreach (plan[i]) begin
      phase_idx = i;
      exp3 = expect_outs(plan[i], o, f, r, m_cond_ex, 1'b1);
      exp2 = expect_outs(plan[i], o, f, r, m_cond_ex, 1'b0);
      cmp_en = 1;
      if (i == abort_at) begin
        @(negedge clk);
        #2;
        chk("abort.pre_mem_write", 8'(mw_mask[i]), 8'd1);
        rst = 1'b1;
        #1;
        cmp_en = 0;
        chk("abort.mem_write3", 8'(mem_write_3), 8'd0);
        chk("abort.mem_write2", 8'(mem_write_2), 8'd0);
        chk("abort.reg_write",  8'(reg_write_3), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_flags = 4'b0000;
        m_cond_ex = 0;
        return;
      end
      @(posedge clk);
      #1;
      if (plan[i] == PH_DECODE) m_cond_ex = cond_ok(c, m_flags);
      if (plan[i] == PH_EXEC && m_cond_ex && f[0]) begin
        m_flags[3:2] = fl[3:2];
        if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) m_flags[1:0] = fl[1:0];
      end
    end
  endtask

  initial begin
    rst = 1'b0; cond = '0; op = '0; funct = '0; rd = '0; flags = '0;
    m_flags = '0; m_cond_ex = 0;
    #2;
    doReset();

    applyStimulus(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0);     // ADD R1,R2,R3
    chk("add.rw_mask", rw_mask3, 8'b0000_1000);
    chk("add.pw_mask", pw_mask, 8'b0000_0001);
    chk("add.alu", 8'(alu_at3[2]), 8'd0);

    applyStimulus(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);  // SUBS, Z=1
    applyStimulus(4'h0, 2'b00, 6'b001000, 4'd3, 4'h0);     // ADDEQ
    chk("addeq_z1.rw_mask", rw_mask3, 8'b0000_1000);
    applyStimulus(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0000);  // SUBS, Z=0
    applyStimulus(4'h0, 2'b00, 6'b001000, 4'd3, 4'h0);
    chk("addeq_z0.rw_mask", rw_mask3, 8'b0000_0000);

    applyStimulus(4'hE, 2'b01, 6'b011001, 4'd4, 4'h0);     // LDR
    chk("ldr.rw_mask", rw_mask3, 8'b0001_0000);
    chk("ldr.adr_mask", adr_mask, 8'b0000_1000);
    applyStimulus(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);     // STR
    chk("str.mw_mask", mw_mask, 8'b0000_1000);

    applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0);     // BEQ, Z=0
    chk("beq_z0.pw_mask", pw_mask, 8'b0000_0001);
    applyStimulus(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
    applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0);     // BEQ, Z=1
    chk("beq_z1.pw_mask", pw_mask, 8'b0000_0101);

    applyStimulus(4'hE, 2'b00, 6'b001001, 4'd6, 4'b0011);  // ADDS -> NZCV 0011
    applyStimulus(4'hE, 2'b00, 6'b000011, 4'd5, 4'b1100);  // EORS -> NZ=11, CV kept
    chk("eor.alu3", 8'(alu_at3[2]), 8'b100);
    chk("eor.alu2", 8'(alu_at2[2]), 8'b000);
    chk("eor.rw3", rw_mask3, 8'b0000_1000);
    chk("eor.rw2", rw_mask2, 8'b0000_0000);
    applyStimulus(4'h4, 2'b00, 6'b001000, 4'd1, 4'h0);     // ADDMI
    chk("addmi.rw_mask", rw_mask3, 8'b0000_1000);
    applyStimulus(4'h6, 2'b00, 6'b001000, 4'd1, 4'h0);     // ADDVS
    chk("addvs.rw_mask", rw_mask3, 8'b0000_1000);
    applyStimulus(4'hF, 2'b00, 6'b001000, 4'd1, 4'h0);     // cond 1111
    chk("addnv.rw_mask", rw_mask3, 8'b0000_0000);

    applyStimulus(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0);     // unknown op
    chk("unk.pw_mask", pw_mask, 8'b0000_0001);

    applyStimulus(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0, 3);  // STR aborted in MEMWR
    applyStimulus(4'h1, 2'b00, 6'b001000, 4'd1, 4'h0);     // ADDNE after reset
    chk("addne.rw_mask", rw_mask3, 8'b0000_1000);
    applyStimulus(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0);    // ADD PC
    chk("addpc.pw_mask", pw_mask, 8'b0000_1001);
    applyStimulus(4'hE, 2'b00, 6'b010101, 4'd7, 4'b0100);  // CMP
    chk("cmp.rw_mask", rw_mask3, 8'b0000_0000);
    applyStimulus(4'hE, 2'b00, 6'b111000, 4'd8, 4'h0);     // ORR immediate
    applyStimulus(4'hE, 2'b00, 6'b000000, 4'd9, 4'h0);     // AND

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
